// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, requester IDs and default widths for mem_arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  localparam logic [1:0] REQ_IF = 2'd0;
  localparam logic [1:0] REQ_LD = 2'd1;
  localparam logic [1:0] REQ_ST = 2'd2;
  localparam int W_DEF = 32;
  localparam int TIMEOUT_DEF = 15;
  localparam int STARVE_DEF = 4;
endpackage

// File: rtl/mem_arbiter_arb_picker.sv
// arb_picker: combinational one-hot grant, store > load > fetch unless fetch is starved.
module arb_picker
  import mem_arbiter_pkg::*;
(
  input  logic       i_if_req,
  input  logic       i_ld_req,
  input  logic       i_st_req,
  input  logic       i_starve,
  output logic [2:0] o_grant
);
  logic w_if, w_ld, w_st;
  assign w_if = i_if_req && (i_starve || !(i_st_req || i_ld_req));
  assign w_st = i_st_req && !w_if;
  assign w_ld = i_ld_req && !i_st_req && !w_if;
  always_comb begin
    o_grant = '0;
    o_grant[REQ_IF] = w_if;
    o_grant[REQ_LD] = w_ld;
    o_grant[REQ_ST] = w_st;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester (fetch/load/store) arbiter onto a single memory port,
// one transaction in flight, with fetch anti-starvation and a memory-ack timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int STARVE  = STARVE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_if_req,
  input  logic         i_ld_req,
  input  logic         i_st_req,
  input  logic [W-1:0] i_if_addr,
  input  logic [W-1:0] i_ld_addr,
  input  logic [W-1:0] i_st_addr,
  input  logic [W-1:0] i_st_wdata,
  input  logic [3:0]   i_st_be,
  output logic         o_if_ack,
  output logic         o_ld_ack,
  output logic         o_st_ack,
  output logic [W-1:0] o_if_rdata,
  output logic [W-1:0] o_ld_rdata,
  output logic         o_bus_err,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  output logic [3:0]   o_mem_be,
  input  logic         i_mem_ack,
  input  logic [W-1:0] i_mem_rdata
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE + 1);

  state_t       r_state, w_next;
  logic [1:0]   r_win;
  logic [W-1:0] r_addr, r_wdata, r_if_rdata, r_ld_rdata;
  logic [3:0]   r_be;
  logic         r_we, r_err;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_starve;
  logic [2:0]   w_grant;
  logic         w_any, w_busy, w_done, w_timeout, w_finish;

  assign w_any     = i_if_req || i_ld_req || i_st_req;
  assign w_busy    = r_state == ST_BUSY;
  assign w_done    = r_state == ST_DONE;
  assign w_timeout = r_tcnt == TW'(TIMEOUT - 1);
  assign w_finish  = w_busy && (i_mem_ack || w_timeout);

  arb_picker u_picker (
    .i_if_req (i_if_req),
    .i_ld_req (i_ld_req),
    .i_st_req (i_st_req),
    .i_starve (r_starve == SW'(STARVE)),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: w_next = w_any ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_next = w_finish ? ST_DONE : ST_BUSY;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_win      <= REQ_IF;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_tcnt     <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_ld_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) begin
        r_win    <= w_grant[REQ_ST] ? REQ_ST : w_grant[REQ_LD] ? REQ_LD : REQ_IF;
        r_addr   <= w_grant[REQ_ST] ? i_st_addr : w_grant[REQ_LD] ? i_ld_addr : i_if_addr;
        r_wdata  <= w_grant[REQ_ST] ? i_st_wdata : '0;
        r_be     <= w_grant[REQ_ST] ? i_st_be : 4'hF;
        r_we     <= w_grant[REQ_ST];
        r_tcnt   <= '0;
        r_starve <= w_grant[REQ_IF] ? '0 :
                    (i_if_req && r_starve != SW'(STARVE)) ? r_starve + 1'b1 : r_starve;
      end
      if (w_busy)
        r_tcnt <= r_tcnt + 1'b1;
      // An ack landing on the final timeout cycle still counts as success.
      if (w_finish) begin
        r_err <= !i_mem_ack;
        if (r_win == REQ_IF)
          r_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
        if (r_win == REQ_LD)
          r_ld_rdata <= i_mem_ack ? i_mem_rdata : '0;
      end
    end
  end

  assign o_mem_req   = w_busy;
  assign o_mem_we    = w_busy && r_we;
  assign o_mem_addr  = w_busy ? r_addr : '0;
  assign o_mem_wdata = w_busy ? r_wdata : '0;
  assign o_mem_be    = w_busy ? r_be : 4'h0;
  assign o_if_ack    = w_done && r_win == REQ_IF;
  assign o_ld_ack    = w_done && r_win == REQ_LD;
  assign o_st_ack    = w_done && r_win == REQ_ST;
  assign o_bus_err   = w_done && r_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_ld_rdata  = r_ld_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a simple memory responder model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_if_req = 0, i_ld_req = 0, i_st_req = 0;
  logic [31:0] i_if_addr = 0, i_ld_addr = 0, i_st_addr = 0, i_st_wdata = 0;
  logic [3:0]  i_st_be = 0;
  logic        o_if_ack, o_ld_ack, o_st_ack, o_bus_err;
  logic [31:0] o_if_rdata, o_ld_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 0;
  logic [31:0] i_mem_rdata = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_ld_req(i_ld_req), .i_st_req(i_st_req),
    .i_if_addr(i_if_addr), .i_ld_addr(i_ld_addr), .i_st_addr(i_st_addr),
    .i_st_wdata(i_st_wdata), .i_st_be(i_st_be),
    .o_if_ack(o_if_ack), .o_ld_ack(o_ld_ack), .o_st_ack(o_st_ack),
    .o_if_rdata(o_if_rdata), .o_ld_rdata(o_ld_rdata), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] id; logic [31:0] rdata; logic err;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // memory responder: acks after mem_delay extra BUSY cycles when enabled
  logic mem_en = 1'b1, spurious = 1'b0;
  int   mem_delay = 0, busy_cnt = 0;
  always @(negedge clk) begin
    busy_cnt    = o_mem_req ? busy_cnt + 1 : 0;
    i_mem_ack   = spurious || (o_mem_req && mem_en && busy_cnt > mem_delay);
    i_mem_rdata = spurious ? 32'hBAD0BAD0 : mem_f(o_mem_addr);
  end

  // ack monitor: pops the scoreboard and releases the acked requester
  exp_t        m_e;
  logic [1:0]  m_id;
  logic [31:0] m_rd;
  always @(negedge clk) begin
    if (rst_n && (o_if_ack || o_ld_ack || o_st_ack)) begin
      n_vec++;
      m_id = o_st_ack ? REQ_ST : o_ld_ack ? REQ_LD : REQ_IF;
      m_rd = o_ld_ack ? o_ld_rdata : o_if_rdata;
      if ($countones({o_if_ack, o_ld_ack, o_st_ack}) != 1) begin
        n_err++;
        $display("FAIL ack_onehot: got acks if/ld/st=%b%b%b, need exactly one", o_if_ack, o_ld_ack, o_st_ack);
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: got ack id=%0d, none expected", m_id);
      end else begin
        m_e = q.pop_front();
        if (m_id !== m_e.id || o_bus_err !== m_e.err || (m_id != REQ_ST && m_rd !== m_e.rdata)) begin
          n_err++;
          $display("FAIL scoreboard: got id=%0d err=%b rdata=%h, expected id=%0d err=%b rdata=%h",
                   m_id, o_bus_err, m_rd, m_e.id, m_e.err, m_e.rdata);
        end
      end
      if (o_if_ack) i_if_req = 0;
      if (o_ld_ack) i_ld_req = 0;
      if (o_st_ack) i_st_req = 0;
    end
  end

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_mem_req, o_mem_we, o_if_ack, o_ld_ack, o_st_ack, o_bus_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {o_mem_req, o_mem_we, o_if_ack, o_ld_ack, o_st_ack, o_bus_err});
    end
    n_vec++;
    if ((o_mem_addr | o_mem_wdata | o_if_rdata | o_ld_rdata | {28'b0, o_mem_be}) !== 32'b0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h ifr=%h ldr=%h, expected all 0",
               o_mem_addr, o_mem_wdata, o_mem_be, o_if_rdata, o_ld_rdata);
    end
    rst_n = 1;
  endtask

  task automatic test_fetch();
    i_if_req = 1; i_if_addr = 32'h100;
    q.push_back('{REQ_IF, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    n_vec++;
    if ({o_mem_req, o_mem_we, o_mem_be} !== 6'b10_1111 || o_mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL fetch_mem: got req=%b we=%b be=%h addr=%h, expected 1 0 f 00000100", o_mem_req, o_mem_we, o_mem_be, o_mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (o_if_ack !== 1 || o_if_rdata !== 32'hDEADBEEF || o_bus_err !== 0) begin
      n_err++;
      $display("FAIL fetch_ack: got ack=%b rdata=%h err=%b, expected 1 deadbeef 0", o_if_ack, o_if_rdata, o_bus_err);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_if_ack !== 0 || o_mem_req !== 0 || o_if_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL fetch_hold: got ack=%b mem_req=%b rdata=%h, expected 0 0 deadbeef", o_if_ack, o_mem_req, o_if_rdata);
    end
  endtask

  task automatic test_priority();
    bit seen = 0;
    i_st_req = 1; i_st_addr = 32'h200; i_st_wdata = 32'h12345678; i_st_be = 4'b0110;
    i_ld_req = 1; i_ld_addr = 32'h300;
    q.push_back('{REQ_ST, 32'h0, 1'b0});
    q.push_back('{REQ_LD, mem_f(32'h300), 1'b0});
    @(negedge clk);
    n_vec++;
    if (o_mem_we !== 1 || o_mem_be !== 4'b0110 || o_mem_addr !== 32'h200 || o_mem_wdata !== 32'h12345678) begin
      n_err++;
      $display("FAIL store_first: got we=%b be=%b addr=%h wdata=%h, expected 1 0110 00000200 12345678",
               o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_ld_ack;
    end
    n_vec++;
    if (!seen || o_ld_rdata !== mem_f(32'h300)) begin
      n_err++;
      $display("FAIL load_second: got seen=%b rdata=%h, expected 1 %h", seen, o_ld_rdata, mem_f(32'h300));
    end
    @(negedge clk);
  endtask

  task automatic test_starve();
    int  nst = 0;
    bit  seen = 0;
    i_if_req = 1; i_if_addr = 32'h400;
    i_st_req = 1; i_st_be = 4'hF;
    repeat (4) q.push_back('{REQ_ST, 32'h0, 1'b0});
    q.push_back('{REQ_IF, mem_f(32'h400), 1'b0});
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = o_if_ack;
      if (o_st_ack) nst++;
      i_st_req = !seen;
      i_st_addr = 32'h500 + c;
    end
    n_vec++;
    if (!seen || nst != 4) begin
      n_err++;
      $display("FAIL starve: got fetch_seen=%b stores_before=%0d, expected 1 4", seen, nst);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc = 0, st_c = -1, ld_c = -1;
    bit seen = 0;
    i_st_req = 1; i_st_addr = 32'h900; i_st_wdata = 32'hCAFEF00D; i_st_be = 4'b1001;
    i_ld_req = 1; i_ld_addr = 32'hA00;
    i_if_req = 1; i_if_addr = 32'hB00;
    q.push_back('{REQ_ST, 32'h0, 1'b0});
    q.push_back('{REQ_LD, mem_f(32'hA00), 1'b0});
    q.push_back('{REQ_IF, mem_f(32'hB00), 1'b0});
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      cyc++;
      if (o_st_ack) st_c = cyc;
      if (o_ld_ack) ld_c = cyc;
      seen = o_if_ack;
    end
    n_vec++;
    if (!seen || st_c != 2 || ld_c != 5 || cyc != 8) begin
      n_err++;
      $display("FAIL back_to_back: got st@%0d ld@%0d if@%0d, expected 2 5 8", st_c, ld_c, seen ? cyc : -1);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  cnt = 0;
    bit  seen = 0;
    mem_en = 0;
    i_ld_req = 1; i_ld_addr = 32'h600;
    q.push_back('{REQ_LD, 32'h0, 1'b1});
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = o_ld_ack;
      if (o_mem_req) cnt++;
    end
    n_vec++;
    if (!seen || cnt != 15 || o_bus_err !== 1 || o_ld_rdata !== 0) begin
      n_err++;
      $display("FAIL timeout: got seen=%b mem_req_cycles=%0d err=%b rdata=%h, expected 1 15 1 0", seen, cnt, o_bus_err, o_ld_rdata);
    end
    @(negedge clk);
    n_vec++;
    if (o_bus_err !== 0) begin
      n_err++;
      $display("FAIL bus_err_clear: got %b, expected 0", o_bus_err);
    end
    mem_en = 1;
  endtask

  task automatic test_reset_busy();
    mem_en = 0;
    i_ld_req = 1; i_ld_addr = 32'h700;
    repeat (3) @(negedge clk);
    n_vec++;
    if (o_mem_req !== 1) begin
      n_err++;
      $display("FAIL busy_before_rst: got mem_req=%b, expected 1", o_mem_req);
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (o_mem_req !== 0) begin
      n_err++;
      $display("FAIL async_rst: got mem_req=%b, expected 0", o_mem_req);
    end
    i_ld_req = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_mem_req, o_if_ack, o_ld_ack, o_st_ack, o_bus_err} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_quiet: got %b, expected 00000", {o_mem_req, o_if_ack, o_ld_ack, o_st_ack, o_bus_err});
    end
    rst_n = 1; mem_en = 1;
    i_ld_req = 1; i_ld_addr = 32'h710;
    q.push_back('{REQ_LD, mem_f(32'h710), 1'b0});
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_ld_ack !== 1 || o_ld_rdata !== mem_f(32'h710)) begin
      n_err++;
      $display("FAIL after_rst: got ack=%b rdata=%h, expected 1 %h", o_ld_ack, o_ld_rdata, mem_f(32'h710));
    end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    bit bad = 0;
    spurious = 1;
    repeat (4) begin
      @(negedge clk);
      if ({o_mem_req, o_if_ack, o_ld_ack, o_st_ack, o_bus_err} !== 5'b0) bad = 1;
    end
    spurious = 0;
    @(negedge clk);
    n_vec++;
    if (bad || o_mem_req !== 0) begin
      n_err++;
      $display("FAIL spurious: got activity=%b mem_req=%b, expected 0 0", bad, o_mem_req);
    end
    i_if_req = 1; i_if_addr = 32'h800;
    q.push_back('{REQ_IF, mem_f(32'h800), 1'b0});
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_if_ack !== 1 || o_if_rdata !== mem_f(32'h800)) begin
      n_err++;
      $display("FAIL post_spurious: got ack=%b rdata=%h, expected 1 %h", o_if_ack, o_if_rdata, mem_f(32'h800));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_spurious();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
